// File: rtl/touch_scan_sequencer.sv
// ---------------------------------------------------------------------------
// touch_scan_sequencer
//
// Fabric-side scan sequencer for a 4-wire resistive touch panel. It drives the
// X and Y plates in turn, waits for the plates to settle, and requests ADC
// conversions. It averages 2**AVG_LOG2 samples per axis and publishes one X/Y
// coordinate pair per completed pen-down scan.
//
// Optional feature (compile-time macro TOUCH_PENUP_CHECK_EN):
//   When defined, a CHECK phase follows the Y conversions. The idle drive
//   pattern is restored for SETTLE_CYCLES, then pen_down is sampled. The
//   coordinates are published only if the pen is still down. When the macro
//   is undefined, every completed scan publishes its result.
//
// Parameters
//   ADC_W          ADC sample width
//   AVG_LOG2       log2 of samples averaged per axis (0..4)
//   SETTLE_CYCLES  cycles of plate drive before the first conversion (>=1)
//
// Ports
//   FAB_CLK      in   fabric clock, rising edge
//   MSS_RESET_N  in   synchronous active-low reset
//   enable       in   scanning allowed
//   pen_down     in   synchronised pen-down sense (meaningful in idle pattern)
//   drv_oe       out  plate output enables {YM,YP,XM,XP}, 0 = tristate
//   drv_val      out  plate drive levels   {YM,YP,XM,XP}
//   adc_ch       out  ADC channel: 0 = sense XP (Y axis), 1 = sense YP (X axis)
//   adc_req      out  conversion request level, held until adc_ack
//   adc_ack      in   one-cycle conversion done, adc_data valid with it
//   adc_data     in   conversion result
//   x_pos/y_pos  out  averaged coordinates, hold last published value
//   coord_valid  out  one-cycle pulse in the cycle x_pos/y_pos first show
//                     a new pair
//   busy         out  high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module touch_scan_sequencer #(
    parameter int ADC_W         = 12,
    parameter int AVG_LOG2      = 2,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic             FAB_CLK,
    input  logic             MSS_RESET_N,
    input  logic             enable,
    input  logic             pen_down,
    output logic [3:0]       drv_oe,
    output logic [3:0]       drv_val,
    output logic             adc_ch,
    output logic             adc_req,
    input  logic             adc_ack,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] x_pos,
    output logic [ADC_W-1:0] y_pos,
    output logic             coord_valid,
    output logic             busy
);

    localparam int ACC_W  = ADC_W + AVG_LOG2;
    localparam int NSAMP  = 1 << AVG_LOG2;
    localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int NCNT_W = AVG_LOG2 + 1;

    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [NCNT_W-1:0] SAMP_LAST   = NCNT_W'(NSAMP - 1);

    // Plate drive patterns, bit order {YM,YP,XM,XP}
    localparam logic [3:0] OE_IDLE  = 4'b1000;
    localparam logic [3:0] VAL_IDLE = 4'b0000;
    localparam logic [3:0] OE_X     = 4'b0011;
    localparam logic [3:0] VAL_X    = 4'b0001;
    localparam logic [3:0] OE_Y     = 4'b1100;
    localparam logic [3:0] VAL_Y    = 4'b0100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE_X,
        S_CONV_X,
        S_SETTLE_Y,
        S_CONV_Y,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [SCNT_W-1:0] settle_cnt, settle_cnt_next;
    logic [NCNT_W-1:0] samp_cnt, samp_cnt_next;
    logic              req_next;
    logic              abort, abort_next;
    logic [ACC_W-1:0]  acc, acc_next;
    logic [ACC_W-1:0]  acc_sum;
    logic [ADC_W-1:0]  x_avg, x_avg_next;
    logic [ADC_W-1:0]  x_pos_next, y_pos_next;
`ifdef TOUCH_PENUP_CHECK_EN
    logic [ADC_W-1:0]  y_avg, y_avg_next;
`endif

    // Truncating average: the accumulator is wide enough for the full sum,
    // so the shift always fits back into ADC_W bits.
    function automatic logic [ADC_W-1:0] avg_of(input logic [ACC_W-1:0] total);
        logic [ACC_W-1:0] shifted;
        shifted = total >> AVG_LOG2;
        return shifted[ADC_W-1:0];
    endfunction

    assign acc_sum = acc + ACC_W'(adc_data);

    // -----------------------------------------------------------------------
    // Next-state, datapath control and decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        samp_cnt_next   = samp_cnt;
        req_next        = adc_req;
        abort_next      = abort;
        acc_next        = acc;
        x_avg_next      = x_avg;
        x_pos_next      = x_pos;
        y_pos_next      = y_pos;
`ifdef TOUCH_PENUP_CHECK_EN
        y_avg_next      = y_avg;
`endif
        drv_oe      = OE_IDLE;
        drv_val     = VAL_IDLE;
        adc_ch      = 1'b0;
        coord_valid = 1'b0;
        busy        = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                // Everything scan-local is cleared here, so an aborted scan
                // never leaks a partial sum into the next one.
                settle_cnt_next = '0;
                samp_cnt_next   = '0;
                acc_next        = '0;
                req_next        = 1'b0;
                abort_next      = 1'b0;
                if (enable && pen_down) begin
                    state_next = S_SETTLE_X;
                end
            end

            S_SETTLE_X, S_SETTLE_Y: begin
                if (state == S_SETTLE_X) begin
                    drv_oe  = OE_X;
                    drv_val = VAL_X;
                    adc_ch  = 1'b1;
                end else begin
                    drv_oe  = OE_Y;
                    drv_val = VAL_Y;
                end
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    // Raise the request so it is visible in the first
                    // conversion cycle.
                    settle_cnt_next = '0;
                    req_next        = 1'b1;
                    state_next      = (state == S_SETTLE_X) ? S_CONV_X : S_CONV_Y;
                end else begin
                    settle_cnt_next = settle_cnt + SCNT_W'(1);
                end
            end

            S_CONV_X, S_CONV_Y: begin
                if (state == S_CONV_X) begin
                    drv_oe  = OE_X;
                    drv_val = VAL_X;
                    adc_ch  = 1'b1;
                end else begin
                    drv_oe  = OE_Y;
                    drv_val = VAL_Y;
                end
                if (adc_req) begin
                    // A conversion in flight must be allowed to finish even
                    // if enable drops; remember the abort until the ack.
                    if (!enable) begin
                        abort_next = 1'b1;
                    end
                    if (adc_ack) begin
                        req_next = 1'b0;
                        if (abort || !enable) begin
                            state_next = S_IDLE;
                        end else if (samp_cnt == SAMP_LAST) begin
                            samp_cnt_next = '0;
                            acc_next      = '0;
                            if (state == S_CONV_X) begin
                                x_avg_next = avg_of(acc_sum);
                                state_next = S_SETTLE_Y;
                            end else begin
`ifdef TOUCH_PENUP_CHECK_EN
                                y_avg_next = avg_of(acc_sum);
                                state_next = S_CHECK;
`else
                                x_pos_next = x_avg;
                                y_pos_next = avg_of(acc_sum);
                                state_next = S_DONE;
`endif
                            end
                        end else begin
                            samp_cnt_next = samp_cnt + NCNT_W'(1);
                            acc_next      = acc_sum;
                        end
                    end
                end else begin
                    // One-cycle gap between samples of the same axis; the
                    // plates stay driven, so no re-settle is needed.
                    if (!enable) begin
                        state_next = S_IDLE;
                    end else begin
                        req_next = 1'b1;
                    end
                end
            end

`ifdef TOUCH_PENUP_CHECK_EN
            S_CHECK: begin
                // Idle pattern again so pen_down is meaningful once settled.
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_next = '0;
                    if (pen_down) begin
                        x_pos_next = x_avg;
                        y_pos_next = y_avg;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    settle_cnt_next = settle_cnt + SCNT_W'(1);
                end
            end
`endif

            S_DONE: begin
                coord_valid = 1'b1;
                state_next  = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control and published-result registers (reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge FAB_CLK) begin
        if (!MSS_RESET_N) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            adc_req    <= 1'b0;
            abort      <= 1'b0;
            x_pos      <= '0;
            y_pos      <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
            samp_cnt   <= samp_cnt_next;
            adc_req    <= req_next;
            abort      <= abort_next;
            x_pos      <= x_pos_next;
            y_pos      <= y_pos_next;
        end
    end

    // -----------------------------------------------------------------------
    // Scan-local data registers; cleared through the idle state instead
    // -----------------------------------------------------------------------
    always_ff @(posedge FAB_CLK) begin
        acc   <= acc_next;
        x_avg <= x_avg_next;
`ifdef TOUCH_PENUP_CHECK_EN
        y_avg <= y_avg_next;
`endif
    end

endmodule
